// File: rtl/board_render.sv
`timescale 1ns/1ps
// board_render
// Walks a 5x5 minesweeper board in row-major order and streams one symbol per
// cell over a valid/ready handshake. The board inputs are snapshotted when a
// frame starts, so the datapath may keep changing while the frame is drawn.
// Optional bubble cycles follow the last column of rows 0-3.
//
// Ports
//   clka          clock, all state updates on the falling edge
//   restart       asynchronous active-high reset
//   start         frame request, honoured only in IDLE
//   mines         mine map, bit i = cell i
//   cleared       cleared-cell map
//   gameover      game-over flag
//   win           win flag
//   cell_ready    downstream accepts the presented cell
//   cell_valid    cell_idx / cell_code / cell_last are valid
//   cell_idx      cell index 0..24
//   cell_code     cell symbol (0..8 count, 9 hidden, A mine, B flagged, C exploded)
//   cell_last     presented cell is index 24
//   busy          frame in progress (SCAN or GAP)
//   display_done  one-cycle frame-complete pulse
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start, outputs quiet
// SCAN   | presenting cell idx, advancing on each accepted transfer
// GAP    | bubble cycles after column 4 of rows 0-3
// DONE   | one-cycle display_done pulse, then back to IDLE

module board_render #(
    parameter int unsigned LINE_GAP = 0
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        start,
    input  logic [24:0] mines,
    input  logic [24:0] cleared,
    input  logic        gameover,
    input  logic        win,
    input  logic        cell_ready,
    output logic        cell_valid,
    output logic [4:0]  cell_idx,
    output logic [3:0]  cell_code,
    output logic        cell_last,
    output logic        busy,
    output logic        display_done
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GAP, S_DONE} state_t;

    // Gap timer is a down-counter loaded with LINE_GAP-1; terminal count 0 ends the gap.
    localparam logic [3:0] GAP_LOAD = 4'((LINE_GAP == 0) ? 0 : LINE_GAP - 1);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic [24:0] mines_q, mines_d;
    logic [24:0] cleared_q, cleared_d;
    logic        gameover_q, gameover_d;
    logic        win_q, win_d;
    logic [3:0]  gap_q, gap_d;

    logic [3:0]  nbr_cnt;
    logic [3:0]  code;
    logic [4:0]  nidx;
    int          r, c;

    // Neighbour count over the 3x3 window, clipped at the board edges.
    always_comb begin
        nbr_cnt = '0;
        nidx    = '0;
        r       = 0;
        c       = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(row_q) + dr;
                c = int'(col_q) + dc;
                if (!(dr == 0 && dc == 0) && r >= 0 && r < 5 && c >= 0 && c < 5) begin
                    nidx    = 5'(r * 5 + c);
                    nbr_cnt = nbr_cnt + 4'(mines_q[nidx]);
                end
            end
        end
    end

    always_comb begin
        code = 4'h9;
        if (cleared_q[idx_q] && mines_q[idx_q])
            code = 4'hC;
        else if (cleared_q[idx_q])
            code = nbr_cnt;
        else if (mines_q[idx_q] && win_q)
            code = 4'hB;
        else if (mines_q[idx_q] && gameover_q)
            code = 4'hA;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        row_d      = row_q;
        col_d      = col_q;
        mines_d    = mines_q;
        cleared_d  = cleared_q;
        gameover_d = gameover_q;
        win_d      = win_q;
        gap_d      = gap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mines_d    = mines;
                    cleared_d  = cleared;
                    gameover_d = gameover;
                    win_d      = win;
                    idx_d      = '0;
                    row_d      = '0;
                    col_d      = '0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cell_ready) begin
                    if (idx_q == 5'd24) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        if (col_q == 3'd4) begin
                            // idx != 24 here, so col 4 implies row 0..3
                            col_d = '0;
                            row_d = row_q + 3'd1;
                            if (LINE_GAP != 0) begin
                                gap_d   = GAP_LOAD;
                                state_d = S_GAP;
                            end
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0)
                    state_d = S_SCAN;
                else
                    gap_d = gap_q - 4'd1;
            end
            S_DONE: begin
                idx_d   = '0;
                row_d   = '0;
                col_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge clka or posedge restart) begin
        if (restart) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            mines_q    <= '0;
            cleared_q  <= '0;
            gameover_q <= 1'b0;
            win_q      <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            mines_q    <= mines_d;
            cleared_q  <= cleared_d;
            gameover_q <= gameover_d;
            win_q      <= win_d;
            gap_q      <= gap_d;
        end
    end

    assign cell_valid   = (state_q == S_SCAN);
    assign cell_idx     = idx_q;
    assign cell_code    = (state_q == S_SCAN) ? code : 4'h0;
    assign cell_last    = (state_q == S_SCAN) && (idx_q == 5'd24);
    assign busy         = (state_q == S_SCAN) || (state_q == S_GAP);
    assign display_done = (state_q == S_DONE);

endmodule

// File: tb/tb_board_render.sv
`timescale 1ns/1ps
module tb_board_render;

    typedef logic [3:0] codes_t [25];
    typedef struct packed {
        logic [4:0] idx;
        logic [3:0] code;
        logic       last;
    } cell_t;

    localparam logic [24:0] MINES   = 25'h000802A;   // cells 1,3,5,15
    localparam logic [24:0] CLR_SAFE = 25'h1000411;  // cells 0,4,10,24

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        restart = 1'b1;
    logic        start = 1'b0, start_g = 1'b0;
    logic [24:0] mines = '0, cleared = '0;
    logic        gameover = 1'b0, win = 1'b0;
    logic        cell_ready = 1'b1, ready_g = 1'b1;

    logic        cell_valid, cell_last, busy, display_done;
    logic [4:0]  cell_idx;
    logic [3:0]  cell_code;
    logic        valid_g, last_g, busy_g, done_g;
    logic [4:0]  idx_g;
    logic [3:0]  code_g;

    board_render #(.LINE_GAP(0)) dut (
        .clka(clka), .restart(restart), .start(start), .mines(mines),
        .cleared(cleared), .gameover(gameover), .win(win), .cell_ready(cell_ready),
        .cell_valid(cell_valid), .cell_idx(cell_idx), .cell_code(cell_code),
        .cell_last(cell_last), .busy(busy), .display_done(display_done));

    board_render #(.LINE_GAP(2)) dut_g (
        .clka(clka), .restart(restart), .start(start_g), .mines(mines),
        .cleared(cleared), .gameover(gameover), .win(win), .cell_ready(ready_g),
        .cell_valid(valid_g), .cell_idx(idx_g), .cell_code(code_g),
        .cell_last(last_g), .busy(busy_g), .display_done(done_g));

    int    checks = 0;
    int    errors = 0;
    cell_t exp_q[$];
    int    xfer_cnt = 0;
    int    done_cnt = 0;

    codes_t safe_c, loss_c, win_c;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wait_neg();
        @(negedge clka);
        #1;
    endtask

    task automatic push_frame(input codes_t cds, input int n);
        cell_t e;
        for (int i = 0; i < n; i++) begin
            e.idx  = 5'(i);
            e.code = cds[i];
            e.last = (i == 24);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        wait_neg();
        start = 1'b0;
        chk("first_valid", cell_valid, 1);
        chk("first_idx", cell_idx, 0);
    endtask

    task automatic finish_frame(input int d0, input int x0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            wait_neg();
            t++;
        end
        chk("done_seen", done_cnt, d0 + 1);
        chk("sb_empty", exp_q.size(), 0);
        chk("xfer_total", xfer_cnt - x0, 25);
        wait_neg();
        chk("idle_valid", cell_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    // Monitor: compares every accepted cell against the scoreboard queue.
    initial begin
        cell_t e;
        cell_t held;
        logic  prev_hold, prev_done, prev_last;
        prev_hold = 1'b0;
        prev_done = 1'b0;
        prev_last = 1'b0;
        held = '0;
        forever begin
            @(posedge clka);
            if (restart) begin
                prev_hold = 1'b0;
                prev_done = 1'b0;
                prev_last = 1'b0;
            end else begin
                if (cell_valid && cell_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cell_idx", cell_idx, e.idx);
                        chk("cell_code", cell_code, e.code);
                        chk("cell_last", cell_last, e.last);
                    end
                    xfer_cnt++;
                end
                if (prev_hold) begin
                    chk("hold_valid", cell_valid, 1);
                    chk("hold_idx", cell_idx, held.idx);
                    chk("hold_code", cell_code, held.code);
                    chk("hold_last", cell_last, held.last);
                end
                if (display_done) begin
                    chk("done_after_last", prev_last, 1);
                    chk("done_busy", busy, 0);
                    chk("done_valid", cell_valid, 0);
                    done_cnt++;
                end
                if (prev_done)
                    chk("done_width", display_done, 0);
                prev_hold = cell_valid && !cell_ready;
                held.idx  = cell_idx;
                held.code = cell_code;
                held.last = cell_last;
                prev_done = display_done;
                prev_last = cell_valid && cell_ready && cell_last;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, x0, t, s, last_s, inval, xf;
        logic seen_done;

        for (int i = 0; i < 25; i++) begin
            safe_c[i] = 4'h9;
            loss_c[i] = 4'h9;
        end
        safe_c[0] = 4'h2; safe_c[4] = 4'h1; safe_c[10] = 4'h2; safe_c[24] = 4'h0;
        loss_c[1] = 4'hC; loss_c[3] = 4'hA; loss_c[5] = 4'hA; loss_c[15] = 4'hA;
        win_c = '{4'h2, 4'hB, 4'h2, 4'hB, 4'h1,
                  4'hB, 4'h2, 4'h2, 4'h1, 4'h1,
                  4'h2, 4'h2, 4'h0, 4'h0, 4'h0,
                  4'hB, 4'h1, 4'h0, 4'h0, 4'h0,
                  4'h1, 4'h1, 4'h0, 4'h0, 4'h0};

        // reset state
        #2;
        chk("rst_valid", cell_valid, 0);
        chk("rst_idx", cell_idx, 0);
        chk("rst_code", cell_code, 0);
        chk("rst_last", cell_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", display_done, 0);
        wait_neg();
        restart = 1'b0;
        wait_neg();

        // safe frame
        mines = MINES; cleared = CLR_SAFE; gameover = 1'b0; win = 1'b0;
        d0 = done_cnt; x0 = xfer_cnt;
        push_frame(safe_c, 25);
        start_frame();
        finish_frame(d0, x0);

        // loss frame
        cleared = 25'h0000002; gameover = 1'b1;
        d0 = done_cnt; x0 = xfer_cnt;
        push_frame(loss_c, 25);
        start_frame();
        finish_frame(d0, x0);

        // win frame with backpressure, input changes and a stray start
        cleared = ~MINES; gameover = 1'b1; win = 1'b1;
        d0 = done_cnt; x0 = xfer_cnt;
        push_frame(win_c, 25);
        start_frame();
        mines = '1; cleared = '0; gameover = 1'b0; win = 1'b0;
        t = 0;
        while (!(cell_valid && cell_idx == 5'd7) && t < 50) begin
            wait_neg();
            t++;
        end
        chk("reach_idx7", cell_idx, 7);
        cell_ready = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) wait_neg();
        cell_ready = 1'b1;
        start = 1'b0;
        finish_frame(d0, x0);

        // reset while idx 12 is presented
        mines = MINES; cleared = CLR_SAFE; gameover = 1'b0; win = 1'b0;
        d0 = done_cnt;
        push_frame(safe_c, 12);
        start_frame();
        t = 0;
        while (!(cell_valid && cell_idx == 5'd12) && t < 50) begin
            wait_neg();
            t++;
        end
        chk("reach_idx12", cell_idx, 12);
        restart = 1'b1;
        #1;
        chk("mid_rst_valid", cell_valid, 0);
        chk("mid_rst_idx", cell_idx, 0);
        chk("mid_rst_code", cell_code, 0);
        chk("mid_rst_last", cell_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", display_done, 0);
        wait_neg();
        restart = 1'b0;
        wait_neg();
        chk("mid_rst_sb_empty", exp_q.size(), 0);
        chk("mid_rst_no_done", done_cnt, d0);
        x0 = xfer_cnt;
        push_frame(safe_c, 25);
        start_frame();
        finish_frame(d0, x0);

        // LINE_GAP=2 instance
        start_g = 1'b1;
        wait_neg();
        start_g = 1'b0;
        chk("gap_first_valid", valid_g, 1);
        s = 0; last_s = -1; inval = 0; xf = 0; seen_done = 1'b0;
        while (s < 100 && !seen_done) begin
            if (done_g) begin
                seen_done = 1'b1;
            end else begin
                if (!valid_g && busy_g) inval++;
                if (valid_g) begin
                    xf++;
                    if (last_g) last_s = s;
                end
                wait_neg();
                s++;
            end
        end
        chk("gap_done", seen_done, 1);
        chk("gap_last_xfer", last_s + 1, 33);
        chk("gap_bubbles", inval, 8);
        chk("gap_xfers", xf, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_render.md
BOARD_RENDER -- requirements
Module: board_render

Interface
REQ-001 SHALL have parameter LINE_GAP, default 0, meaning the number of bubble cycles (legal range 0..15) inserted after column 4 of rows 0-3.
REQ-002 SHALL have port clka, input, 1 bit: the single clock; all state updates on the negative edge.
REQ-003 SHALL have port restart, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: render request, sampled only in IDLE.
REQ-005 SHALL have port mines, input, 25 bits: mine map, bit i = cell i.
REQ-006 SHALL have port cleared, input, 25 bits: cleared-cell map from the datapath.
REQ-007 SHALL have port gameover, input, 1 bit: game-over flag.
REQ-008 SHALL have port win, input, 1 bit: win flag.
REQ-009 SHALL have port cell_ready, input, 1 bit: downstream accepts the current cell.
REQ-010 SHALL have port cell_valid, output, 1 bit: cell_idx and cell_code are valid.
REQ-011 SHALL have port cell_idx, output, 5 bits: cell index 0..24.
REQ-012 SHALL have port cell_code, output, 4 bits: symbol for the cell.
REQ-013 SHALL have port cell_last, output, 1 bit: current cell is index 24.
REQ-014 SHALL have port busy, output, 1 bit: high in SCAN and GAP.
REQ-015 SHALL have port display_done, output, 1 bit: one-cycle frame-complete pulse.

Function
REQ-016 SHALL implement states IDLE, SCAN, GAP and DONE.
REQ-017 IDLE with start=1 SHALL snapshot mines, cleared, gameover and win, set cell_idx=0, and enter SCAN; the first cell_valid appears on the next clka edge.
REQ-018 Changes to mines, cleared, gameover or win after the snapshot SHALL NOT affect the frame in progress.
REQ-019 start SHALL be ignored in SCAN, GAP and DONE.
REQ-020 In SCAN, cell_valid=1; a transfer occurs on an edge where cell_valid and cell_ready are both 1.
REQ-021 While cell_ready=0, cell_idx, cell_code and cell_last SHALL hold stable.
REQ-022 Cell order SHALL be row-major: row = idx/5, col = idx%5, with idx 0 = row 0, col 0.
REQ-023 Cell code SHALL be the in-bounds neighbour count (dr, dc in -1..1, excluding self) of snapshot mines, 4 bits, 0..8.
REQ-024 cell_code SHALL be selected by the first matching rule in this order:
- cleared & mine -> 4'hC (exploded)
- cleared & !mine -> neighbour count
- mine & win -> 4'hB
- mine & gameover & !win -> 4'hA
- otherwise -> 4'h9 (hidden)
REQ-025 Codes 4'hD-4'hF SHALL never be emitted.
REQ-026 After a transfer with col=4 and row<4, if LINE_GAP>0 the block SHALL enter GAP for LINE_GAP cycles with cell_valid=0, then return to SCAN with the next idx.
REQ-027 If LINE_GAP=0, or the transferred cell is not at col=4 with row<4, SCAN SHALL continue directly with idx+1.
REQ-028 A transfer of idx 24 SHALL enter DONE: display_done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-029 In IDLE and DONE, cell_valid=0 and cell_last=0.
REQ-030 The idx counter SHALL never exceed 24 and SHALL never wrap within a frame.

Reset
REQ-031 restart=1 SHALL immediately force IDLE, cell_valid=0, cell_idx=0, cell_code=0, cell_last=0, busy=0, display_done=0, snapshots=0 and gap counter=0, independent of clka.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no display_done; the next start SHALL begin at idx 0.

Verification
REQ-033 Safe frame: mines=bits{1,3,5,15}, cleared=bits{0,4,10,24}, gameover=0, win=0, cell_ready=1, start pulse -> codes idx0=2, idx4=1, idx10=2, idx24=0, all other cells 9; cell_last with idx24; display_done one cycle later.
REQ-034 Loss: same mines, cleared=bit1, gameover=1 -> idx1=C, idx3=A, idx5=A, idx15=A, all others 9.
REQ-035 Win: same mines, cleared=~mines, gameover=1, win=1 -> idx1, idx3, idx5, idx15 = B; idx6=2; idx24=0.
REQ-036 Backpressure: cell_ready=0 for 3 cycles while idx7 is presented -> idx7 and its code held stable, no skip or duplicate, 25 transfers total.
REQ-037 LINE_GAP=2, cell_ready=1: first valid 1 cycle after start; last transfer 33 cycles after first valid; cell_valid=0 on exactly 8 cycles within the frame.
REQ-038 Reset mid-frame: restart asserted while idx12 is presented -> all outputs 0 immediately; the following start emits from idx0.
